// File: rtl/mm_ctrl_pkg.sv
// Shared definitions for the main-memory access controller: FSM states,
// requester port ids and default bus geometry.
package mm_ctrl_pkg;

    localparam int unsigned DEF_ADDR_W      = 8;
    localparam int unsigned DEF_DATA_W      = 8;
    localparam int unsigned DEF_WAIT_CYCLES = 2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mm_state_e;

endpackage

// File: rtl/mm_rr_arb2.sv
// Two-request round-robin arbiter; a tie goes to the port not granted last.
module mm_rr_arb2
    import mm_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic accept_i,
    output logic gnt_c_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_c_o = PORT_I;
        if (i_req_i && d_req_i) begin
            gnt_c_o = ~last_q;
        end else if (d_req_i) begin
            gnt_c_o = PORT_D;
        end
        last_d = accept_i ? gnt_c_o : last_q;
    end

    // Reset to data so that fetch wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= PORT_D;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mm_access_ctrl.sv
// Shares one level-sensitive MM port between a fetch and a data requester,
// holding each read/write strobe for WAIT_CYCLES clocks before completion.
module mm_access_ctrl
    import mm_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W      = DEF_ADDR_W,
    parameter int unsigned DATA_W      = DEF_DATA_W,
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mm_read,
    output logic              mm_write,
    output logic [ADDR_W-1:0] mm_addr,
    output logic [DATA_W-1:0] mm_wdata,
    input  logic [DATA_W-1:0] mm_rdata,
    output logic              busy,
    output logic              owner
);

    localparam int unsigned       CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    mm_state_e         state_q,   state_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic              owner_q,   owner_d;
    logic              we_q,      we_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              rd_q,      rd_d;
    logic              wr_q,      wr_d;
    logic              i_done_q,  i_done_d;
    logic              d_done_q,  d_done_d;
    logic              busy_q,    busy_d;
    logic              accept_c;
    logic              gnt_c;

    mm_rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .i_req_i  (i_req),
        .d_req_i  (d_req),
        .accept_i (accept_c),
        .gnt_c_o  (gnt_c)
    );

    // Next-state and registered-output logic; strobes only ever come from flops.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        rd_d      = 1'b0;
        wr_d      = 1'b0;
        i_done_d  = 1'b0;
        d_done_d  = 1'b0;
        busy_d    = 1'b0;
        accept_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    accept_c = 1'b1;
                    state_d  = ACCESS;
                    cnt_d    = CNT_LOAD;
                    owner_d  = gnt_c;
                    busy_d   = 1'b1;
                    if (gnt_c == PORT_D) begin
                        we_d    = d_we;
                        addr_d  = d_addr;
                        wdata_d = d_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = i_addr;
                    end
                    rd_d = ~we_d;
                    wr_d = we_d;
                end
            end
            ACCESS: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (owner_q == PORT_D) begin
                        d_done_d = 1'b1;
                    end else begin
                        i_done_d = 1'b1;
                    end
                    if (!we_q) begin
                        if (owner_q == PORT_D) begin
                            d_rdata_d = mm_rdata;
                        end else begin
                            i_rdata_d = mm_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    rd_d  = ~we_q;
                    wr_d  = we_q;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            owner_q   <= PORT_I;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            i_done_q  <= i_done_d;
            d_done_q  <= d_done_d;
            busy_q    <= busy_d;
        end
    end

    assign mm_read  = rd_q;
    assign mm_write = wr_q;
    assign mm_addr  = addr_q;
    assign mm_wdata = wdata_q;
    assign i_done   = i_done_q;
    assign d_done   = d_done_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = busy_q;
    assign owner    = owner_q;

endmodule

// File: tb/tb_mm_access_ctrl.sv
// Bench for mm_access_ctrl: directed vector table, hand-written corner
// sequences and random traffic, all against a transaction-level model.
module tb_mm_access_ctrl;
    import mm_ctrl_pkg::*;

    localparam int W = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       i_req = 1'b0;
    logic [7:0] i_addr = '0;
    logic       i_done;
    logic [7:0] i_rdata;
    logic       d_req = 1'b0;
    logic       d_we = 1'b0;
    logic [7:0] d_addr = '0;
    logic [7:0] d_wdata = '0;
    logic       d_done;
    logic [7:0] d_rdata;
    logic       mm_read;
    logic       mm_write;
    logic [7:0] mm_addr;
    logic [7:0] mm_wdata;
    logic [7:0] mm_rdata;
    logic       busy;
    logic       owner;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mm_access_ctrl #(.ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_done   (i_done),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .mm_read  (mm_read),
        .mm_write (mm_write),
        .mm_addr  (mm_addr),
        .mm_wdata (mm_wdata),
        .mm_rdata (mm_rdata),
        .busy     (busy),
        .owner    (owner)
    );

    // MM model: read data becomes valid only after the strobe has been high a full cycle.
    logic [7:0] mem [0:255];
    int         rd_age = 0;
    always @(posedge clk) begin
        if (mm_write) mem[mm_addr] <= mm_wdata;
        rd_age <= mm_read ? rd_age + 1 : 0;
    end
    assign mm_rdata = (mm_read && rd_age >= 1) ? mem[mm_addr] : 8'hEE;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
        end
    endtask

    // Transaction-level reference: grant time g, strobe for edges g..g+W-1, done after g+W.
    logic [7:0]  m_mem [0:255];
    bit          m_valid = 0, m_active = 0, m_last = 1, m_port = 0, m_we = 0, rst_at_edge = 0;
    logic [7:0]  m_addr = '0, m_wdata = '0, m_irdata = '0, m_drdata = '0;
    int          m_g = 0, cyc = 0, k;
    logic [37:0] exp_v = '0;
    logic [37:0] act_v;
    bit          e_rd, e_wr, e_busy, e_idone, e_ddone;

    assign act_v = {mm_read, mm_write, busy, i_done, d_done, owner, mm_addr, mm_wdata, i_rdata, d_rdata};

    always @(posedge clk) begin
        cyc++;
        rst_at_edge = reset;
        if (m_active && cyc == m_g + 1 && m_we) m_mem[m_addr] = m_wdata;
        if (reset) begin
            m_valid = 1; m_active = 0; m_last = 1; m_port = 0;
            m_addr = '0; m_wdata = '0; m_irdata = '0; m_drdata = '0;
        end else begin
            if (m_active && cyc == m_g + W && !m_we) begin
                if (m_port) m_drdata = m_mem[m_addr];
                else        m_irdata = m_mem[m_addr];
            end
            if ((!m_active || cyc >= m_g + W + 2) && (i_req || d_req)) begin
                m_port   = (i_req && d_req) ? ~m_last : d_req;
                m_last   = m_port;
                m_active = 1;
                m_g      = cyc;
                if (m_port) begin
                    m_we = d_we; m_addr = d_addr; m_wdata = d_wdata;
                end else begin
                    m_we = 0; m_addr = i_addr;
                end
            end
        end
        k       = cyc - m_g;
        e_rd    = m_active && k < W && !m_we;
        e_wr    = m_active && k < W && m_we;
        e_busy  = m_active && k <= W;
        e_idone = m_active && k == W && !m_port;
        e_ddone = m_active && k == W && m_port;
        exp_v   = {e_rd, e_wr, e_busy, e_idone, e_ddone, m_port, m_addr, m_wdata, m_irdata, m_drdata};
    end

    // Every cycle: full output vector against the model, and address/data stability under a strobe.
    bit          prev_strobe = 0;
    logic [15:0] prev_aw = '0;
    always @(negedge clk) begin
        if (m_valid) begin
            check("cycle_outputs", 64'(act_v), 64'(exp_v));
            if (prev_strobe && !rst_at_edge)
                check("addr_stable", 64'({mm_addr, mm_wdata}), 64'(prev_aw));
        end
        prev_strobe = mm_read | mm_write;
        prev_aw     = {mm_addr, mm_wdata};
    end

    task automatic do_access(input bit port, input bit we, input logic [7:0] addr,
                             input logic [7:0] wdata, output int done_at, output int strobes);
        done_at = -1;
        strobes = 0;
        if (port) begin
            d_req = 1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            i_req = 1; i_addr = addr;
        end
        for (int n = 1; n <= 20 && done_at < 0; n++) begin
            @(negedge clk);
            if (mm_read || mm_write) strobes++;
            if (port ? d_done : i_done) begin
                done_at = n;
                i_req = 0; d_req = 0;
            end
        end
        i_req = 0; d_req = 0;
    endtask

    typedef struct packed {
        bit         port;
        bit         we;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_i;
        logic [7:0] exp_d;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int done_at, strobes, dcnt, bcnt;
        int q_port[$];
        int q_cyc[$];
        int exp_cyc[4];
        int exp_port[4];

        for (int a = 0; a < 256; a++) begin
            mem[a]   = 8'h00;
            m_mem[a] = 8'h00;
        end
        exp_cyc  = '{3, 7, 11, 15};
        exp_port = '{0, 1, 0, 1};

        tbl[0] = '{1'b1, 1'b1, 8'h10, 8'hA5, 8'h00, 8'h00};
        tbl[1] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hA5, 8'h00};
        tbl[3] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'hA5, 8'h00};
        tbl[4] = '{1'b1, 1'b0, 8'h20, 8'h00, 8'hA5, 8'h3C};
        tbl[5] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h3C, 8'h3C};
        tbl[6] = '{1'b1, 1'b1, 8'h10, 8'h5A, 8'h3C, 8'h3C};
        tbl[7] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'h5A, 8'h3C};
        tbl[8] = '{1'b1, 1'b1, 8'hFF, 8'h77, 8'h5A, 8'h3C};
        tbl[9] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A, 8'h77};

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(act_v), 64'(0));
        reset = 0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            do_access(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, done_at, strobes);
            check($sformatf("vec%0d_done_latency", i), 64'(done_at), 64'(3));
            check($sformatf("vec%0d_strobe_cycles", i), 64'(strobes), 64'(W));
            check($sformatf("vec%0d_i_rdata", i), 64'(i_rdata), 64'(tbl[i].exp_i));
            check($sformatf("vec%0d_d_rdata", i), 64'(d_rdata), 64'(tbl[i].exp_d));
            @(negedge clk);
        end

        // Both ports held: grants alternate starting with fetch.
        i_req = 1; i_addr = 8'h10;
        d_req = 1; d_we = 0; d_addr = 8'h01;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clk);
            if (i_done) begin q_port.push_back(0); q_cyc.push_back(n); end
            if (d_done) begin q_port.push_back(1); q_cyc.push_back(n); end
        end
        i_req = 0; d_req = 0;
        check("tie_done_count", 64'(q_port.size()), 64'(4));
        for (int j = 0; j < 4 && j < q_port.size(); j++) begin
            check($sformatf("tie%0d_port", j), 64'(q_port[j]), 64'(exp_port[j]));
            check($sformatf("tie%0d_cycle", j), 64'(q_cyc[j]), 64'(exp_cyc[j]));
        end
        repeat (2) @(negedge clk);

        // Reset during the second ACCESS cycle of a write.
        d_req = 1; d_we = 1; d_addr = 8'h20; d_wdata = 8'h3C;
        @(negedge clk);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("rst_mid_strobes", 64'({mm_read, mm_write}), 64'(0));
        check("rst_mid_busy", 64'(busy), 64'(0));
        check("rst_mid_d_done", 64'(d_done), 64'(0));
        check("rst_mid_addr", 64'(mm_addr), 64'(0));
        @(negedge clk);
        check("rst_hold_busy", 64'(busy), 64'(0));
        reset = 0;
        @(negedge clk);
        check("post_rst_busy", 64'(busy), 64'(1));
        check("post_rst_write", 64'(mm_write), 64'(1));
        d_req = 0;
        repeat (4) @(negedge clk);

        // Data read whose request drops right after the grant.
        d_req = 1; d_we = 0; d_addr = 8'h20;
        dcnt = 0; bcnt = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (n == 1) d_req = 0;
            if (d_done) dcnt++;
            if (busy) bcnt++;
        end
        check("drop_done_count", 64'(dcnt), 64'(1));
        check("drop_busy_cycles", 64'(bcnt), 64'(W + 1));
        check("drop_busy_end", 64'(busy), 64'(0));
        check("drop_d_rdata", 64'(d_rdata), 64'(8'h3C));

        // Random traffic, including occasional resets, against the model.
        for (int n = 0; n < 3000; n++) begin
            i_req   = ($urandom_range(0, 2) != 0);
            d_req   = ($urandom_range(0, 2) != 0);
            d_we    = $urandom_range(0, 1) == 1;
            i_addr  = 8'($urandom_range(0, 15));
            d_addr  = 8'($urandom_range(0, 15));
            d_wdata = 8'($urandom);
            reset   = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        reset = 0; i_req = 0; d_req = 0;
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mm_access_ctrl.md
# mm_access_ctrl

Sequencing controller and two-port arbiter for the 8-bit main memory (MM). It shares the single MM port between an instruction-fetch requester (read-only) and a data requester (read/write). It converts each clocked request/done handshake into a level-sensitive MM read or write strobe. The strobe is held for a fixed number of clock cycles so that MM's propagation delay is covered before read data is captured.

## Interface
- ADDR_W, 8, address width (MM address bus)
- DATA_W, 8, data width
- WAIT_CYCLES, 2, cycles a strobe is held before completion; ≥1; WAIT_CYCLES × clock period must exceed MM delay

- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request, level
- i_addr  in  ADDR_W  fetch address
- i_done  out  1  one-cycle completion pulse
- i_rdata  out  DATA_W  fetched data, registered
- d_req  in  1  data request, level
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_done  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  read data, registered
- mm_read  out  1  to MM read strobe
- mm_write  out  1  to MM write strobe
- mm_addr  out  ADDR_W  to MM address bus
- mm_wdata  out  DATA_W  to MM write-data input
- mm_rdata  in  DATA_W  from MM read-data output
- busy  out  1  high in ACCESS and RESP
- owner  out  1  0 = fetch, 1 = data; port of current or last access

## Operation
- FSM states and transitions:
  - IDLE → ACCESS when any request is high.
  - ACCESS → RESP when the wait counter reaches 0.
  - RESP → IDLE unconditionally.
- Arbitration in IDLE:
  - Only one request high: that port is granted.
  - Both high: grant goes to the port not granted last (round-robin).
  - last_grant resets to data, so fetch wins the first tie.
- Latching at the grant edge:
  - owner, address, we (fetch forces we = 0) and wdata are latched into internal registers.
  - Requester inputs are ignored until the next IDLE.
- ACCESS behaviour:
  - mm_read = ~we and mm_write = we, driven from registers (glitch-free).
  - mm_addr and mm_wdata are driven from the latched registers.
  - The counter loads WAIT_CYCLES−1 at grant and decrements each cycle.
  - On the edge where the counter is 0 and the access is a read, mm_rdata is captured into the owner's rdata register.
- RESP behaviour:
  - Both strobes are low.
  - mm_addr and mm_wdata stay unchanged, so MM never sees an address change while a strobe is high.
  - The owner's done is high for exactly this cycle.
- rdata holds its value until the next completed read on the same port. Writes leave d_rdata unchanged.
- A requester dropping req mid-access is ignored: the access completes and done still pulses.
- A requester still holding req in RESP is re-arbitrated in the following IDLE (back-to-back access).
- Counter width is $clog2(WAIT_CYCLES+1).

## Timing
- Grant edge = edge N, where IDLE samples a request.
- Strobe high in cycles N+1 … N+WAIT_CYCLES: exactly WAIT_CYCLES cycles.
- done high in cycle N+WAIT_CYCLES+1.
- rdata is valid in the same cycle as done.
- Minimum period for one port holding req: WAIT_CYCLES+2 cycles (ACCESS, RESP, IDLE).
- Reset values:
  - state IDLE; counter 0; last_grant = data
  - mm_read, mm_write, i_done, d_done, busy = 0
  - mm_addr, mm_wdata, i_rdata, d_rdata = 0
  - owner = 0
- Reset in any state:
  - All outputs take their reset values at that edge.
  - An in-flight access is aborted with no done; a partial MM write is accepted.
- Requests high during reset are not granted until the first IDLE after reset deasserts.

## Structure
- Shared package mm_ctrl_pkg holds:
  - state enum {IDLE, ACCESS, RESP}
  - port-id constants PORT_I = 0, PORT_D = 1
  - default ADDR_W, DATA_W, WAIT_CYCLES
- One natural sub-module: mm_rr_arb2, a two-request round-robin arbiter holding last_grant. Its inputs are the two requests plus an accept strobe from the FSM; its output is a grant id.

## Test plan
All scenarios use WAIT_CYCLES = 2 with a behavioural MM model (all cells 0 at start, delay < 2 clocks).
- **Data write then fetch read.** After reset, d_req with we = 1, addr 0x10, wdata 0xA5 → mm_write high exactly 2 cycles with mm_addr 0x10 and mm_wdata 0xA5; d_done pulses 3 cycles after the grant edge. Then i_req at 0x10 → i_rdata = 0xA5 on i_done.
- **Simultaneous requests.** i_req and d_req (read, 0x01) rise together and are held → grant order fetch, data, fetch, data; owner toggles; each done pulses once per 4 cycles alternately.
- **Unwritten location.** Data read of 0xFF with nothing written → d_rdata = 0x00; i_rdata unchanged.
- **Reset mid-write.** Reset asserted in the second ACCESS cycle of a write to 0x20 / 0x3C → next edge: strobes 0, busy 0, no d_done, mm_addr 0x00. The FSM grants again only after reset deasserts.
- **Request dropped mid-access.** d_req deasserted during ACCESS → d_done still pulses once, then no further access and busy stays 0.
- **Address stability.** For every access, mm_addr and mm_wdata are constant from the strobe rising edge through the RESP cycle (assertion checked on all scenarios).
